// File: rtl/rgb_mode_controller.sv
// Button-driven colour sequencer for the etch-a-sketch RGB LED: synchronise and
// debounce one pushbutton, step an 8-colour FSM per press, drive the LED via fixed-duty PWM.
module rgb_mode_controller #(
    parameter int T        = 100,
    parameter int DUTY     = 25,
    parameter int DEBOUNCE = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic [2:0] rgb,
    output logic [2:0] mode,
    output logic       press
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(T);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(T - 1);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RED     = 3'd1,
        ST_GREEN   = 3'd2,
        ST_BLUE    = 3'd3,
        ST_YELLOW  = 3'd4,
        ST_CYAN    = 3'd5,
        ST_MAGENTA = 3'd6,
        ST_WHITE   = 3'd7
    } mode_e;

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          press_q, press_d;
    mode_e         state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    rgb_q, rgb_d;
    logic [2:0]    mask;
    logic          pwm_on;

    // Debounce: stable only follows s2 after DEBOUNCE consecutive differing cycles.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (s2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press_d = stable_q & ~stable_dly_q;

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
        end
    end

    assign pwm_on = (32'(pcnt_q) < 32'(DUTY));

    // Mode FSM next state and colour mask; WHITE + 1 overflows back to OFF.
    always_comb begin
        state_d = state_q;
        mask    = 3'b000;
        if (press_q) begin
            state_d = mode_e'(state_q + 3'd1);
        end
        case (state_q)
            ST_OFF:     mask = 3'b000;
            ST_RED:     mask = 3'b100;
            ST_GREEN:   mask = 3'b010;
            ST_BLUE:    mask = 3'b001;
            ST_YELLOW:  mask = 3'b110;
            ST_CYAN:    mask = 3'b011;
            ST_MAGENTA: mask = 3'b101;
            ST_WHITE:   mask = 3'b111;
            default:    mask = 3'b000;
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign rgb_d[gi] = mask[gi] & pwm_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            press_q      <= 1'b0;
            pcnt_q       <= '0;
            rgb_q        <= 3'b000;
        end else begin
            s1_q         <= button;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            press_q      <= press_d;
            pcnt_q       <= pcnt_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb   = rgb_q;
    assign mode  = state_q;
    assign press = press_q;

endmodule

// File: tb/tb_rgb_mode_controller.sv
// Directed bench for rgb_mode_controller: main instance at DUTY=25 plus
// always-dark (DUTY=0) and always-lit (DUTY=T) instances sharing the same stimulus.
module tb_rgb_mode_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] rgb, rgb_dark, rgb_full;
    logic [2:0] mode, mode_dark, mode_full;
    logic       press, press_dark, press_full;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rgb_mode_controller #(.T(100), .DUTY(25), .DEBOUNCE(10)) dut (
        .clk(clk), .rst(rst), .button(button),
        .rgb(rgb), .mode(mode), .press(press)
    );
    rgb_mode_controller #(.T(100), .DUTY(0), .DEBOUNCE(10)) dut_dark (
        .clk(clk), .rst(rst), .button(button),
        .rgb(rgb_dark), .mode(mode_dark), .press(press_dark)
    );
    rgb_mode_controller #(.T(100), .DUTY(100), .DEBOUNCE(10)) dut_full (
        .clk(clk), .rst(rst), .button(button),
        .rgb(rgb_full), .mode(mode_full), .press(press_full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    logic [2:0] exp_mode [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0] exp_mask [8] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111, 3'b000};

    initial begin
        int pc, first, on_cnt, off_cnt, other, full_bad, dark_bad, rises, side_press;
        logic [2:0] orv, prev;

        // Reset
        rst = 1'b1;
        button = 1'b0;
        tick;
        check("reset_mode", mode, 0);
        check("reset_rgb", rgb, 0);
        check("reset_press", press, 0);
        tick;
        rst = 1'b0;
        pc = 0; other = 0; side_press = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            pc += press;
            side_press += (press_dark | press_full);
            if (rgb != 3'b000) other++;
        end
        check("idle_press", pc, 0);
        check("idle_side_press", side_press, 0);
        check("idle_rgb", other, 0);
        check("idle_mode", mode, 0);
        $display("reset+idle: mode=%0d rgb=%b presses=%0d", mode, rgb, pc);

        // Single clean press; tick 1 is the sampling edge E, press expected after E+12
        button = 1'b1;
        pc = 0; first = -1;
        for (int k = 1; k <= 50; k++) begin
            tick;
            if (press) begin
                pc++;
                if (first < 0) first = k;
            end
        end
        button = 1'b0;
        check("press_latency", first, 13);
        check("press_count", pc, 1);
        check("press_mode", mode, 1);
        $display("single press: first_press_tick=%0d presses=%0d mode=%0d", first, pc, mode);

        on_cnt = 0; off_cnt = 0; other = 0; full_bad = 0; dark_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (rgb == 3'b100) on_cnt++;
            else if (rgb == 3'b000) off_cnt++;
            else other++;
            if (rgb_full != 3'b100) full_bad++;
            if (rgb_dark != 3'b000) dark_bad++;
        end
        check("pwm_on_cycles", on_cnt, 25);
        check("pwm_off_cycles", off_cnt, 75);
        check("pwm_other", other, 0);
        check("pwm_full_lit", full_bad, 0);
        check("pwm_dark", dark_bad, 0);
        $display("pwm window: on=%0d off=%0d other=%0d", on_cnt, off_cnt, other);

        rises = 0;
        prev = rgb;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (prev == 3'b000 && rgb != 3'b000) rises++;
            prev = rgb;
        end
        check("pwm_contiguous", rises, 2);

        // Bounce rejection
        pc = 0;
        for (int i = 0; i < 60; i++) begin
            button = ((i % 6) < 3);
            tick;
            pc += press;
        end
        button = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            pc += press;
        end
        check("bounce_press", pc, 0);
        check("bounce_mode", mode, 1);
        $display("bounce: presses=%0d mode=%0d", pc, mode);

        // Full cycle and wrap from a fresh reset
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check("cycle_start_mode", mode, 0);
        for (int p = 0; p < 8; p++) begin
            pc = 0; orv = 3'b000; on_cnt = 0; other = 0; full_bad = 0; dark_bad = 0;
            button = 1'b1;
            for (int k = 1; k <= 130; k++) begin
                tick;
                if (k == 30) button = 1'b0;
                pc += press;
                if (k >= 21) begin
                    orv |= rgb;
                    if (rgb != 3'b000 && rgb != exp_mask[p]) other++;
                    if (rgb_full != exp_mask[p]) full_bad++;
                    if (rgb_dark != 3'b000) dark_bad++;
                    if (k <= 120 && rgb != 3'b000) on_cnt++;
                end
            end
            check("cycle_press", pc, 1);
            check("cycle_mode", mode, exp_mode[p]);
            check("cycle_mask", orv, exp_mask[p]);
            check("cycle_on_cycles", on_cnt, (exp_mask[p] != 3'b000) ? 25 : 0);
            check("cycle_bad_rgb", other, 0);
            check("cycle_full_lit", full_bad, 0);
            check("cycle_dark", dark_bad, 0);
            $display("press %0d: mode=%0d mask=%b on=%0d", p + 1, mode, orv, on_cnt);
        end

        // One more press so the mid-debounce reset has a non-OFF mode to clear
        button = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            tick;
            if (k == 30) button = 1'b0;
        end
        check("rewrap_mode", mode, 1);
        check("rewrap_dark_mode", mode_dark, 1);
        check("rewrap_full_mode", mode_full, 1);

        // Reset five cycles into the debounce count, button kept held
        button = 1'b1;
        for (int k = 1; k <= 7; k++) tick;
        rst = 1'b1;
        tick;
        check("midrst_mode", mode, 0);
        check("midrst_rgb", rgb, 0);
        check("midrst_press", press, 0);
        tick;
        rst = 1'b0;
        pc = 0; first = -1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (press) begin
                pc++;
                if (first < 0) first = k;
            end
        end
        check("midrst_latency", first, 13);
        check("midrst_count", pc, 1);
        check("midrst_after_mode", mode, 1);
        $display("mid-debounce reset: first_press_tick=%0d presses=%0d mode=%0d", first, pc, mode);
        button = 1'b0;
        for (int i = 0; i < 20; i++) tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
